// File: rtl/pipe_hazard_ctrl.sv
// LC-3b pipeline hazard controller: PC and pipeline-register load/clear strobes for D-mem stalls, MEM redirects, load-use and I-fetch stalls.
// Optional saturating perf counters (dstall_cnt, bubble_cnt, flush_cnt) when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_W = 3
`ifdef PIPE_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken_mem,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_mem_read,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             clear_if_id,
  output logic             load_id_ex,
  output logic             clear_id_ex,
  output logic             load_ex_mem,
  output logic             clear_ex_mem,
  output logic             load_mem_wb,
  output logic             clear_mem_wb
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {INIT, RUN, IDISCARD} state_e;

  state_e state_q, state_d;
  logic   dstall;
  logic   hazard;
  logic   discard_done;

  assign dstall = dmem_req & ~dmem_resp;
  assign hazard = ex_mem_read & ((id_use_src1 & (id_src1 == ex_dest)) |
                                 (id_use_src2 & (id_src2 == ex_dest)));
  // The stale fetch from before a redirect retires on the first response seen.
  assign discard_done = (state_q == IDISCARD) & imem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    clear_if_id  = 1'b0;
    load_id_ex   = 1'b1;
    clear_id_ex  = 1'b0;
    load_ex_mem  = 1'b1;
    clear_ex_mem = 1'b0;
    load_mem_wb  = 1'b1;
    clear_mem_wb = 1'b0;

    if (!rst_n || state_q == INIT) begin
      load_pc      = 1'b0;
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_ex_mem = 1'b1;
      clear_mem_wb = 1'b1;
      state_d      = RUN;
    end else if (dstall) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      clear_mem_wb = 1'b1;
      if (discard_done) state_d = RUN;
    end else if (br_taken_mem) begin
      clear_if_id  = 1'b1;
      clear_id_ex  = 1'b1;
      clear_ex_mem = 1'b1;
      state_d      = imem_resp ? RUN : IDISCARD;
    end else if (hazard) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      clear_id_ex  = 1'b1;
      if (discard_done) state_d = RUN;
    end else if (state_q == IDISCARD || !imem_resp) begin
      load_pc      = 1'b0;
      clear_if_id  = 1'b1;
      if (discard_done) state_d = RUN;
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             active;
  logic             perf_dstall, perf_flush, perf_bubble;
  logic [CNT_W-1:0] dstall_cnt_q, bubble_cnt_q, flush_cnt_q;

  assign active      = rst_n & (state_q != INIT);
  assign perf_dstall = active & dstall;
  assign perf_flush  = active & ~dstall & br_taken_mem;
  assign perf_bubble = active & ~dstall & ~br_taken_mem & hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dstall_cnt_q <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (perf_dstall && !(&dstall_cnt_q)) dstall_cnt_q <= dstall_cnt_q + CNT_ONE;
      if (perf_bubble && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      if (perf_flush  && !(&flush_cnt_q))  flush_cnt_q  <= flush_cnt_q + CNT_ONE;
    end
  end

  assign dstall_cnt = dstall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_resp = 1'b1, dmem_req = 1'b0, dmem_resp = 1'b0, br_taken_mem = 1'b0;
  logic [2:0] id_src1 = 3'd1, id_src2 = 3'd2, ex_dest = 3'd5;
  logic       id_use_src1 = 1'b0, id_use_src2 = 1'b0, ex_mem_read = 1'b0;
  logic       load_pc, load_if_id, clear_if_id, load_id_ex, clear_id_ex;
  logic       load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb;
`ifdef PIPE_PERF_EN
  logic [3:0] dstall_cnt, bubble_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {load_pc, load_if_id, clear_if_id, load_id_ex, clear_id_ex, load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb}
  localparam logic [8:0] V_INIT   = 9'b0_11_11_11_11;
  localparam logic [8:0] V_NORM   = 9'b1_10_10_10_10;
  localparam logic [8:0] V_DSTALL = 9'b0_00_00_00_11;
  localparam logic [8:0] V_FLUSH  = 9'b1_11_11_11_10;
  localparam logic [8:0] V_HAZ    = 9'b0_00_11_10_10;
  localparam logic [8:0] V_ISTALL = 9'b0_11_10_10_10;

  logic [8:0] strobes;
  assign strobes = {load_pc, load_if_id, clear_if_id, load_id_ex, clear_id_ex,
                    load_ex_mem, clear_ex_mem, load_mem_wb, clear_mem_wb};

  pipe_hazard_ctrl #(
    .REG_W(3)
`ifdef PIPE_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .br_taken_mem(br_taken_mem), .id_src1(id_src1),
    .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .load_pc(load_pc),
    .load_if_id(load_if_id), .clear_if_id(clear_if_id), .load_id_ex(load_id_ex),
    .clear_id_ex(clear_id_ex), .load_ex_mem(load_ex_mem), .clear_ex_mem(clear_ex_mem),
    .load_mem_wb(load_mem_wb), .clear_mem_wb(clear_mem_wb)
`ifdef PIPE_PERF_EN
    , .dstall_cnt(dstall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic im, input logic dq, input logic dr, input logic br,
                       input logic emr, input logic [2:0] ed, input logic u1,
                       input logic [2:0] s1, input logic u2, input logic [2:0] s2);
    @(negedge clk);
    imem_resp = im; dmem_req = dq; dmem_resp = dr; br_taken_mem = br;
    ex_mem_read = emr; ex_dest = ed; id_use_src1 = u1; id_src1 = s1;
    id_use_src2 = u2; id_src2 = s2;
    #1;
  endtask

  task automatic idle(input logic im);
    drive(im, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd1, 1'b1, 3'd2);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    idle(1'b1);
    @(negedge clk); rst_n = 1'b1;
    idle(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      checks++;
      if (strobes !== V_INIT) begin errors++; $display("FAIL reset_hold cyc%0d got %b want %b", i, strobes, V_INIT); end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (strobes !== V_INIT) begin errors++; $display("FAIL init_cycle got %b want %b", strobes, V_INIT); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL post_init got %b want %b", strobes, V_NORM); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
    checks++;
    if (strobes !== V_HAZ) begin errors++; $display("FAIL load_use_src1 got %b want %b", strobes, V_HAZ); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL load_use_after got %b want %b", strobes, V_NORM); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd1, 1'b1, 3'd6);
    checks++;
    if (strobes !== V_HAZ) begin errors++; $display("FAIL load_use_src2 got %b want %b", strobes, V_HAZ); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 3'd6);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL unused_src got %b want %b", strobes, V_NORM); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 3'd6);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL not_load got %b want %b", strobes, V_NORM); end
    idle(1'b0);
    checks++;
    if (strobes !== V_ISTALL) begin errors++; $display("FAIL istall_run got %b want %b", strobes, V_ISTALL); end
  endtask

  task automatic test_dstall_branch();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
      checks++;
      if (strobes !== V_DSTALL) begin errors++; $display("FAIL dstall_freeze cyc%0d got %b want %b", i, strobes, V_DSTALL); end
    end
    // Data response ends the stall, so the held branch redirects in the same cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    checks++;
    if (strobes !== V_FLUSH) begin errors++; $display("FAIL dstall_release got %b want %b", strobes, V_FLUSH); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL dstall_after got %b want %b", strobes, V_NORM); end
  endtask

  task automatic test_redirect_discard();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    checks++;
    if (strobes !== V_FLUSH) begin errors++; $display("FAIL redirect got %b want %b", strobes, V_FLUSH); end
    idle(1'b0);
    checks++;
    if (strobes !== V_ISTALL) begin errors++; $display("FAIL discard_wait got %b want %b", strobes, V_ISTALL); end
    idle(1'b1);
    checks++;
    if (strobes !== V_ISTALL) begin errors++; $display("FAIL discard_resp got %b want %b", strobes, V_ISTALL); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL discard_exit got %b want %b", strobes, V_NORM); end
    // Second redirect while discarding keeps discarding.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    checks++;
    if (strobes !== V_FLUSH) begin errors++; $display("FAIL second_redirect got %b want %b", strobes, V_FLUSH); end
    idle(1'b1);
    checks++;
    if (strobes !== V_ISTALL) begin errors++; $display("FAIL second_discard got %b want %b", strobes, V_ISTALL); end
    // Hazard during discard: hazard strobes, response still ends the discard.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 1'b0, 3'd0);
    checks++;
    if (strobes !== V_HAZ) begin errors++; $display("FAIL hazard_in_discard got %b want %b", strobes, V_HAZ); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL hazard_discard_exit got %b want %b", strobes, V_NORM); end
  endtask

  task automatic test_hazard_vs_flush();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3);
    checks++;
    if (strobes !== V_FLUSH) begin errors++; $display("FAIL flush_over_hazard got %b want %b", strobes, V_FLUSH); end
    idle(1'b1);
    checks++;
    if (strobes !== V_NORM) begin errors++; $display("FAIL flush_hazard_after got %b want %b", strobes, V_NORM); end
  endtask

  // Reference model: pipeline position tracked as "still initialising" and
  // "a stale pre-redirect fetch is outstanding"; strobes chosen by rule priority.
  bit m_init, m_stale;
  int m_dst, m_bub, m_fl;

  function automatic logic [8:0] model_exp();
    bit ds, hz;
    ds = dmem_req && !dmem_resp;
    hz = ex_mem_read && ((id_use_src1 && id_src1 == ex_dest) || (id_use_src2 && id_src2 == ex_dest));
    if (!rst_n || m_init) return V_INIT;
    if (ds) return V_DSTALL;
    if (br_taken_mem) return V_FLUSH;
    if (hz) return V_HAZ;
    if (m_stale || !imem_resp) return V_ISTALL;
    return V_NORM;
  endfunction

  function automatic int sat15(input int v);
    return (v < 15) ? v + 1 : v;
  endfunction

  task automatic model_step();
    logic [8:0] e;
    e = model_exp();
    if (!rst_n) begin
      m_init = 1; m_stale = 0; m_dst = 0; m_bub = 0; m_fl = 0;
    end else if (m_init) begin
      m_init = 0;
    end else begin
      if (e == V_DSTALL) m_dst = sat15(m_dst);
      if (e == V_HAZ)    m_bub = sat15(m_bub);
      if (e == V_FLUSH)  m_fl  = sat15(m_fl);
      if (e == V_FLUSH) m_stale = !imem_resp;
      else if (imem_resp) m_stale = 0;
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    @(negedge clk); rst_n = 1'b0;
    m_init = 1; m_stale = 0; m_dst = 0; m_bub = 0; m_fl = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n        = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      imem_resp    = ($urandom_range(0, 3) != 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_resp    = $urandom_range(0, 1);
      br_taken_mem = ($urandom_range(0, 5) == 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_dest      = 3'($urandom_range(0, 3));
      id_src1      = 3'($urandom_range(0, 3));
      id_src2      = 3'($urandom_range(0, 3));
      id_use_src1  = $urandom_range(0, 1);
      id_use_src2  = $urandom_range(0, 1);
      #1;
      e = model_exp();
      checks++;
      if (strobes !== e) begin errors++; $display("FAIL random cyc%0d got %b want %b", i, strobes, e); end
`ifdef PIPE_PERF_EN
      checks++;
      if ({dstall_cnt, bubble_cnt, flush_cnt} !== {4'(m_dst), 4'(m_bub), 4'(m_fl)}) begin
        errors++;
        $display("FAIL random_cnt cyc%0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 dstall_cnt, bubble_cnt, flush_cnt, m_dst, m_bub, m_fl);
      end
`endif
      model_step();
    end
    rst_n = 1'b1;
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 3'd1, 1'b0, 3'd2);
    idle(1'b1);
    checks++;
    if (dstall_cnt !== 4'd15) begin errors++; $display("FAIL perf_saturate got %0d want 15", dstall_cnt); end
    idle(1'b1);
    checks++;
    if (dstall_cnt !== 4'd15) begin errors++; $display("FAIL perf_hold got %0d want 15", dstall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_dstall_branch();
    test_redirect_discard();
    test_hazard_vs_flush();
    test_random();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
